// File: rtl/im2col_mapper_if.sv
// Pixel-in / window-out stream bundle for im2col_mapper.
// The slave modport is the mapper side; master is the producer/consumer side.
interface im2col_mapper_if #(
    parameter int data_width = 16,
    parameter int row        = 25
);
    logic [data_width-1:0]          pixel_in;
    logic                           pixel_valid;
    logic                           pixel_ready;
    logic [row-1:0][data_width-1:0] map_2_iarray;
    logic                           map_valid;
    logic                           map_ready;

    modport master (
        output pixel_in, pixel_valid, map_ready,
        input  pixel_ready, map_2_iarray, map_valid
    );

    modport slave (
        input  pixel_in, pixel_valid, map_ready,
        output pixel_ready, map_2_iarray, map_valid
    );
endinterface

// File: rtl/im2col_mapper.sv
// Streaming im2col: raster pixels in, one K*K window vector out per valid position
// (stride 1, no padding), using K-1 line buffers and a sliding K*K window register.
module im2col_mapper #(
    parameter int data_width = 16,
    parameter int K          = 5,
    parameter int row        = 25,
    parameter int img_w      = 32,
    parameter int img_h      = 32
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           start,
    im2col_mapper_if.slave bus,
    output logic [9:0]     win_cnt,
    output logic           busy,
    output logic           done
);
    localparam int CW    = (img_w > 1) ? $clog2(img_w) : 1;
    localparam int RW    = (img_h > 1) ? $clog2(img_h) : 1;
    localparam int TOTAL = (img_h - K + 1) * (img_w - K + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(img_w - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(img_h - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);
    localparam logic [9:0]    WIN_LAST = 10'(TOTAL - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t                              state_q, state_d;
    logic [CW-1:0]                       col_q, col_d;
    logic [RW-1:0]                       row_q, row_d;
    logic [K-1:0][K-1:0][data_width-1:0] win_q, win_d;
    logic [row-1:0][data_width-1:0]      map_q, map_d;
    logic                                mvld_q, mvld_d;
    logic                                pend_q, pend_d;
    logic [9:0]                          wcnt_q, wcnt_d;

    // lb_q[0] holds the previous image row, lb_q[K-2] the oldest one
    logic [data_width-1:0]               lb_q [K-1][img_w];
    logic [K-1:0][data_width-1:0]        new_col;

    logic pix_rdy, accept, consume, load, start_acc, last_pix, win_hit;

    assign pix_rdy   = (state_q == S_LOAD) && (!mvld_q || bus.map_ready);
    assign accept    = bus.pixel_valid && pix_rdy;
    assign consume   = mvld_q && bus.map_ready;
    assign load      = pend_q && (!mvld_q || bus.map_ready);
    assign start_acc = start && (state_q == S_IDLE);
    assign last_pix  = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign win_hit   = (col_q >= COL_WIN) && (row_q >= ROW_WIN);

    // Column entering the window: K-1 buffered rows above, live pixel at the bottom
    for (genvar kr = 0; kr < K - 1; kr++) begin : g_col
        assign new_col[kr] = lb_q[K-2-kr][col_q];
    end
    assign new_col[K-1] = bus.pixel_in;

    always_ff @(posedge clk) begin
        if (accept) begin
            lb_q[0][col_q] <= bus.pixel_in;
            for (int j = 1; j < K - 1; j++) begin
                lb_q[j][col_q] <= lb_q[j-1][col_q];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (accept && last_pix) state_d = S_DRAIN;
            S_DRAIN: if (consume && (wcnt_q == WIN_LAST)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        win_d  = win_q;
        map_d  = map_q;
        mvld_d = mvld_q;
        pend_d = pend_q;
        wcnt_d = wcnt_q;

        // A completed window waits in win_q until the output slot is free
        if (load) begin
            for (int kr = 0; kr < K; kr++) begin
                for (int kc = 0; kc < K; kc++) begin
                    map_d[kr*K + kc] = win_q[kr][kc];
                end
            end
            mvld_d = 1'b1;
            pend_d = 1'b0;
        end else if (consume) begin
            mvld_d = 1'b0;
        end

        if (accept) begin
            pend_d = win_hit;
            for (int kr = 0; kr < K; kr++) begin
                for (int kc = 0; kc < K - 1; kc++) begin
                    win_d[kr][kc] = win_q[kr][kc+1];
                end
                win_d[kr][K-1] = new_col[kr];
            end
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (consume) wcnt_d = wcnt_q + 10'd1;

        if (start_acc) begin
            col_d  = '0;
            row_d  = '0;
            pend_d = 1'b0;
            wcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            map_q   <= '0;
            mvld_q  <= 1'b0;
            pend_q  <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            map_q   <= map_d;
            mvld_q  <= mvld_d;
            pend_q  <= pend_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign bus.pixel_ready  = pix_rdy;
    assign bus.map_valid    = mvld_q;
    assign bus.map_2_iarray = map_q;
    assign win_cnt          = wcnt_q;
    assign busy             = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign done             = (state_q == S_DONE);
endmodule

// File: tb/tb_im2col_mapper.sv
// Randomized frames against a direct window-extraction model of the image.
module tb_im2col_mapper;
    localparam int DW   = 16;
    localparam int K    = 5;
    localparam int ROW  = 25;
    localparam int W    = 32;
    localparam int H    = 32;
    localparam int NPIX = W * H;
    localparam int OW   = W - K + 1;
    localparam int NWIN = OW * (H - K + 1);

    logic       clk;
    logic       nrst;
    logic       start;
    logic [9:0] win_cnt;
    logic       busy;
    logic       done;

    im2col_mapper_if #(.data_width(DW), .row(ROW)) bus ();

    im2col_mapper #(
        .data_width(DW), .K(K), .row(ROW), .img_w(W), .img_h(H)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .start   (start),
        .bus     (bus),
        .win_cnt (win_cnt),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [DW-1:0] img [NPIX];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Window w covers top-left pixel (w / OW, w % OW); element kr*K+kc at bits of slot kr*K+kc
    function automatic logic [ROW*DW-1:0] exp_win(input int w);
        logic [ROW*DW-1:0] v;
        int r0, c0;
        r0 = w / OW;
        c0 = w % OW;
        v  = '0;
        for (int kr = 0; kr < K; kr++)
            for (int kc = 0; kc < K; kc++)
                v[(kr*K + kc)*DW +: DW] = img[(r0 + kr)*W + c0 + kc];
        return v;
    endfunction

    task automatic run_frame(input int vpct, input int rpct, input int bp_at, input int rst_at,
                             input int bs_at, input bit rnd, input bit wrap);
        int pidx, widx, cyc, bp_left, dones;
        bit bp_used, bs_used, snap_ok, fin, acc, cons;
        logic [ROW*DW-1:0] snap, got;
        pidx = 0; widx = 0; cyc = 0; bp_left = 0; dones = 0;
        bp_used = 0; bs_used = 0; snap_ok = 0; fin = 0;
        snap = '0;
        for (int i = 0; i < NPIX; i++) img[i] = rnd ? DW'($urandom) : DW'(i);

        // Pixels offered while idle must not be taken
        bus.pixel_valid = 1'b1;
        bus.pixel_in    = img[0];
        bus.map_ready   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("pre_start_rdy", bus.pixel_ready, 0);
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(negedge clk);
        chk("start_cycle_rdy", bus.pixel_ready, 0);
        @(posedge clk); #1;
        start = 1'b0;

        while (!fin && cyc < 20000) begin
            bus.map_ready   = (bp_left > 0) ? 1'b0 : ($urandom_range(99) < rpct);
            bus.pixel_valid = (pidx < NPIX) && ($urandom_range(99) < vpct);
            bus.pixel_in    = bus.pixel_valid ? img[pidx] : DW'($urandom);
            start = 1'b0;
            if (bs_at >= 0 && !bs_used && widx >= bs_at) begin
                start   = 1'b1;
                bs_used = 1;
            end
            @(negedge clk);
            got  = bus.map_2_iarray;
            acc  = bus.pixel_valid && bus.pixel_ready;
            cons = bus.map_valid && bus.map_ready;
            chk("win_cnt", win_cnt, widx);
            if (dones > 0) begin
                chk("done_width", done, 0);
                fin = 1;
            end else begin
                chk("busy", busy, !done);
                if (done) begin
                    dones++;
                    chk("done_win_cnt", win_cnt, NWIN);
                end
            end
            if (wrap && pidx >= 5*W + 2 && pidx <= 5*W + 4) chk("wrap_vld", bus.map_valid, 0);
            if (wrap && pidx == 5*W + 4) chk("wrap_cnt", widx, OW);
            if (bp_left > 0 && bus.map_valid) begin
                chk("bp_rdy", bus.pixel_ready, 0);
                if (snap_ok) chk("bp_hold", got, snap);
                else begin
                    snap    = got;
                    snap_ok = 1;
                end
            end
            if (cons) begin
                if (widx < NWIN) chk("window", got, exp_win(widx));
                else chk("extra_window", widx, NWIN - 1);
                if (!rnd && widx == 0)  chk("w0_e24", got[24*DW +: DW], 132);
                if (!rnd && widx == 1)  chk("w1_e0", got[0 +: DW], 1);
                if (!rnd && widx == 28) chk("w28_e0", got[0 +: DW], 32);
                widx++;
            end
            if (acc) pidx++;
            if (rst_at >= 0 && widx >= rst_at) begin
                #2 nrst = 1'b0;
                #1;
                chk("rst_rdy", bus.pixel_ready, 0);
                chk("rst_vld", bus.map_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_wcnt", win_cnt, 0);
                chk("rst_map", bus.map_2_iarray, 0);
                @(posedge clk); #1;
                nrst = 1'b1;
                bus.pixel_valid = 1'b1;
                bus.map_ready   = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("post_rst_vld", bus.map_valid, 0);
                    chk("post_rst_rdy", bus.pixel_ready, 0);
                    @(posedge clk); #1;
                end
                return;
            end
            @(posedge clk); #1;
            cyc++;
            if (bp_left > 0) bp_left--;
            else if (bp_at >= 0 && !bp_used && widx >= bp_at) begin
                bp_left = 10;
                bp_used = 1;
            end
        end
        chk("frame_timeout", fin, 1);
        chk("total", widx, NWIN);
    endtask

    initial begin
        nrst = 1'b0;
        start = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.pixel_in = '0;
        bus.map_ready = 1'b0;
        #3;
        chk("reset_rdy", bus.pixel_ready, 0);
        chk("reset_vld", bus.map_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_wcnt", win_cnt, 0);
        chk("reset_map", bus.map_2_iarray, 0);
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;

        run_frame(100, 100, -1,  -1,  -1, 0, 1); // basic ramp frame + row wrap
        run_frame(50,  100, 300, -1, 200, 0, 0); // gapped input, backpressure, start while busy
        run_frame(70,  60,  -1,  -1,  -1, 1, 0); // random pixels, random ready
        run_frame(100, 100, -1, 100,  -1, 0, 0); // reset mid-frame
        run_frame(100, 100, -1,  -1,  -1, 0, 0); // full frame after reset

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/im2col_mapper.md
# im2col_mapper

Streaming im2col stage that sits directly upstream of `sys_flag`. It accepts a raster-ordered feature-map pixel stream, for example from the AXI input buffer. It builds every K×K convolution window (stride 1, no padding) and presents each window as one `map_2_iarray` vector of `row` = K·K elements. Each vector is handed to the systolic array under a valid/ready handshake. With the defaults, a 32×32 image and a 5×5 kernel produce 28·28 = 784 windows.

## Interface
Parameters:
- `data_width`, 16, width of each pixel and of each output element
- `K`, 5, kernel dimension
- `row`, 25, output vector length; must equal K·K
- `img_w`, 32, image width in pixels
- `img_h`, 32, image height in pixels

Ports:
- `clk`, input, 1, the only clock; all state changes on its rising edge
- `nrst`, input, 1, asynchronous active-low reset
- `start`, input, 1, one-cycle pulse that begins a frame; ignored unless in IDLE
- `pixel_in`, input, data_width, current pixel, raster order (row-major, top-left first)
- `pixel_valid`, input, 1, `pixel_in` is valid
- `pixel_ready`, output, 1, the mapper accepts the pixel this cycle
- `map_2_iarray`, output, data_width × [row-1:0], window vector to the input array
- `map_valid`, output, 1, `map_2_iarray` holds an unconsumed window
- `map_ready`, input, 1, downstream consumes the window (driven from the `sys_flag` flag/fifo_en path)
- `win_cnt`, output, 10, number of windows consumed in the current frame
- `busy`, output, 1, high in LOAD and DRAIN
- `done`, output, 1, one-cycle pulse after the last window of the frame is consumed

## Operation
- States and transitions:
  - IDLE → LOAD on `start`.
  - LOAD → DRAIN when the final pixel (img_h-1, img_w-1) is accepted.
  - DRAIN → DONE when the last window is consumed.
  - DONE → IDLE unconditionally.
- Pixel acceptance:
  - Accept = `pixel_valid && pixel_ready`.
  - `pixel_ready` = (state == LOAD) && (!`map_valid` || `map_ready`).
- Counters:
  - `col_cnt` runs 0..img_w-1 and `row_cnt` runs 0..img_h-1; both advance on accept only.
  - `col_cnt` wraps to 0 and increments `row_cnt` after column img_w-1.
- Window generation:
  - Use K-1 line buffers of depth img_w plus a K×K window register.
  - Accepting pixel (r,c) with r ≥ K-1 and c ≥ K-1 completes a window.
  - Accepting any other pixel (c < K-1 after a row wrap, or r < K-1) completes no window.
- Vector order: element i = kr·K + kc holds pixel (r-K+1+kr, c-K+1+kc), so element 0 is the top-left pixel and element row-1 is the bottom-right.
- Output register:
  - Loads and sets `map_valid` on the cycle after a window-completing accept.
  - Clears `map_valid` when `map_ready` is high and no new window loads in the same cycle. A simultaneous consume and load keeps `map_valid` high with the new data.
  - `map_2_iarray` holds stable while `map_valid` && !`map_ready`.
- `win_cnt` increments on each `map_valid && map_ready`. It clears to 0 on `start` acceptance.
- DRAIN ends when `win_cnt` reaches (img_h-K+1)·(img_w-K+1) (784 by default).

## Timing
- Reset values (asynchronous on `nrst`=0, also when asserted mid-frame):
  - state = IDLE
  - `pixel_ready` = 0, `map_valid` = 0, `busy` = 0, `done` = 0
  - `win_cnt` = 0, all `map_2_iarray` elements = 0
  - counters and window registers = 0
- Line buffers need no reset; their contents are don't-care until overwritten.
- A mid-frame reset discards the frame. No window is emitted until a new `start`.
- `start` in cycle t puts the block in LOAD at t+1, so `pixel_ready` can first be high at t+1.
- Latency: accept at edge t gives `map_valid` high after edge t+1, i.e. one cycle.
- Throughput: one pixel per cycle and, in steady state, one window per cycle while `map_ready` = 1.
- Backpressure: with `map_valid` = 1 and `map_ready` = 0, `pixel_ready` is 0 in the same cycle (combinational).
- `done` is high for exactly one cycle, the cycle after the final consume edge, with `busy` low in that cycle. `start` during DONE is ignored.
- `pixel_valid` outside LOAD is ignored.

## Test plan
- Basic frame: pixel(r,c) = r·32+c, `map_ready` tied 1.
  - First window: element0=0, element4=4, element5=32, element24=132.
  - Second window: element0=1, element24=133.
  - 29th window: element0=32.
  - Exactly 784 windows, then `done` pulses once and `win_cnt`=784.
- Row wrap: pixels (5,0)…(5,3) accepted → `map_valid` stays 0 and no window is emitted for c<4.
- Backpressure: hold `map_ready`=0 for 10 cycles mid-frame.
  - `map_2_iarray` is unchanged and `pixel_ready`=0 throughout.
  - On release, no window is lost or duplicated; the total is still 784.
- Gapped input: `pixel_valid` random at 50% → identical window sequence to the basic frame.
- Reset mid-frame: `nrst` low after window 100.
  - Outputs immediately go to their reset values.
  - A new `start` with a full frame yields 784 windows, and the first window's element0=0.
- Start protocol:
  - `start` while `busy` is ignored and `win_cnt` continues.
  - Pixels presented before `start` are not accepted (`pixel_ready`=0).
